// File: rtl/rf_sched_pkg.sv
// Shared constants and FSM state type for the register-file write scheduler.
package rf_sched_pkg;
  localparam int NREQ  = 4;
  localparam int AW    = 3;
  localparam int DW    = 4;
  localparam int CNT_W = AW;

  typedef enum logic {
    ARB  = 1'b0,
    INIT = 1'b1
  } state_e;
endpackage

// File: rtl/rr_arb4.sv
// Combinational 4-way round-robin picker; search starts at ptr and wraps.
module rr_arb4 (
  input  logic [3:0] qreq,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic [1:0] idx,
  output logic       vld
);
  logic [7:0] dbl;
  logic [3:0] rot;
  logic [1:0] off;

  always_comb begin
    // rotate so that bit 0 is the requester at ptr
    dbl = {qreq, qreq} >> ptr;
    rot = dbl[3:0];
    off = 2'd0;
    vld = 1'b1;
    if      (rot[0]) off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else if (rot[2]) off = 2'd2;
    else if (rot[3]) off = 2'd3;
    else             vld = 1'b0;
    idx = ptr + off;
    gnt = vld ? (4'b0001 << idx) : 4'b0000;
  end
endmodule

// File: rtl/regfile_write_sched.sv
// Shares the register file write port between four round-robin requesters and a
// hardware init sequence that fills all registers with INIT_DATA.
import rf_sched_pkg::*;

module regfile_write_sched #(
  parameter int NREQ = rf_sched_pkg::NREQ,
  parameter int AW   = rf_sched_pkg::AW,
  parameter int DW   = rf_sched_pkg::DW
) (
  input  logic                 CLK,
  input  logic                 CLRN,
  input  logic [NREQ-1:0]      REQ,
  input  logic [NREQ*AW-1:0]   REQ_ADDR,
  input  logic [NREQ*DW-1:0]   REQ_DATA,
  input  logic                 INIT_REQ,
  input  logic [DW-1:0]        INIT_DATA,
  output logic [NREQ-1:0]      GNT,
  output logic                 WA2,
  output logic                 WA1,
  output logic                 WA0,
  output logic [DW-1:0]        LD_DATA,
  output logic                 WR,
  output logic                 BUSY
);
  state_e          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   wa_q, wa_d;
  logic [DW-1:0]   ld_q, ld_d;
  logic            busy_q, busy_d;

  logic [NREQ-1:0] qreq;
  logic [3:0]      arb_gnt;
  logic [1:0]      arb_idx;
  logic            arb_vld;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;

  // last cycle's grantee sits out one cycle so it can update addr/data
  assign qreq = REQ & ~gnt_q;

  rr_arb4 u_arb (
    .qreq (qreq),
    .ptr  (ptr_q),
    .gnt  (arb_gnt),
    .idx  (arb_idx),
    .vld  (arb_vld)
  );

  assign win_addr = REQ_ADDR[arb_idx*AW +: AW];
  assign win_data = REQ_DATA[arb_idx*DW +: DW];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    wr_d    = 1'b0;
    wa_d    = wa_q;
    ld_d    = ld_q;
    busy_d  = 1'b0;
    case (state_q)
      ARB: begin
        if (INIT_REQ) begin
          state_d = INIT;
        end else if (arb_vld) begin
          gnt_d = arb_gnt;
          wr_d  = 1'b1;
          wa_d  = win_addr;
          ld_d  = win_data;
          ptr_d = arb_idx + 2'd1;
        end
      end
      INIT: begin
        wr_d   = 1'b1;
        wa_d   = cnt_q;
        ld_d   = INIT_DATA;
        busy_d = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == {AW{1'b1}}) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      state_q <= ARB;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      wr_q    <= 1'b0;
      wa_q    <= '0;
      ld_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      wa_q    <= wa_d;
      ld_q    <= ld_d;
      busy_q  <= busy_d;
    end
  end

  assign GNT             = gnt_q;
  assign {WA2, WA1, WA0} = wa_q;
  assign LD_DATA         = ld_q;
  assign WR              = wr_q;
  assign BUSY            = busy_q;
endmodule

// File: tb/tb_regfile_write_sched.sv
// Directed and random checks of the write scheduler against a behavioural model.
module tb_regfile_write_sched;
  logic        CLK = 1'b0;
  logic        CLRN;
  logic [3:0]  REQ;
  logic [11:0] REQ_ADDR;
  logic [15:0] REQ_DATA;
  logic        INIT_REQ;
  logic [3:0]  INIT_DATA;
  logic [3:0]  GNT;
  logic        WA2, WA1, WA0;
  logic [3:0]  LD_DATA;
  logic        WR;
  logic        BUSY;

  regfile_write_sched dut (
    .CLK(CLK), .CLRN(CLRN), .REQ(REQ), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
    .INIT_REQ(INIT_REQ), .INIT_DATA(INIT_DATA), .GNT(GNT),
    .WA2(WA2), .WA1(WA1), .WA0(WA0), .LD_DATA(LD_DATA), .WR(WR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  // register file attached to the write port
  logic [3:0] rf [8];
  always @(posedge CLK) if (WR) rf[{WA2, WA1, WA0}] <= LD_DATA;

  // reference model state
  logic [3:0] m_gnt;
  logic       m_wr, m_busy;
  logic [2:0] m_wa;
  logic [3:0] m_ld;
  int         m_ptr, m_cnt;
  bit         m_init;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_gnt = 4'h0; m_wr = 1'b0; m_wa = 3'd0; m_ld = 4'h0; m_busy = 1'b0;
    m_ptr = 0; m_cnt = 0; m_init = 1'b0;
  endtask

  task automatic m_step();
    int w;
    logic [3:0] last;
    w = -1;
    last = m_gnt;
    if (m_init) begin
      m_gnt = 4'h0; m_wr = 1'b1; m_wa = 3'(m_cnt); m_ld = INIT_DATA; m_busy = 1'b1;
      if (m_cnt == 7) begin m_init = 1'b0; m_cnt = 0; end
      else m_cnt++;
    end else begin
      m_busy = 1'b0;
      if (INIT_REQ) begin
        m_init = 1'b1; m_gnt = 4'h0; m_wr = 1'b0;
      end else begin
        for (int k = 0; k < 4; k++) begin
          int i;
          i = (m_ptr + k) % 4;
          if (w < 0 && REQ[i] && !last[i]) w = i;
        end
        if (w >= 0) begin
          m_gnt = 4'(1 << w);
          m_wr  = 1'b1;
          m_wa  = REQ_ADDR[3*w +: 3];
          m_ld  = REQ_DATA[4*w +: 4];
          m_ptr = (w + 1) % 4;
        end else begin
          m_gnt = 4'h0; m_wr = 1'b0;
        end
      end
    end
  endtask

  task automatic chk_all();
    chk("gnt",  16'(GNT),           16'(m_gnt));
    chk("wr",   16'(WR),            16'(m_wr));
    chk("wa",   16'({WA2,WA1,WA0}), 16'(m_wa));
    chk("ld",   16'(LD_DATA),       16'(m_ld));
    chk("busy", 16'(BUSY),          16'(m_busy));
  endtask

  task automatic tick();
    @(posedge CLK);
    if (!CLRN) m_reset(); else m_step();
    @(negedge CLK);
    chk_all();
  endtask

  initial begin
    logic [3:0] seq [5];
    seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    CLRN = 1'b0; REQ = 4'h0; REQ_ADDR = 12'h0; REQ_DATA = 16'h0;
    INIT_REQ = 1'b0; INIT_DATA = 4'h0;
    m_reset();
    tick(); tick();
    CLRN = 1'b1;

    // all four requesting from reset
    REQ_ADDR = {3'd7, 3'd6, 3'd5, 3'd4};
    REQ_DATA = {4'hD, 4'hC, 4'hB, 4'hA};
    REQ = 4'hF;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_gnt", 16'(GNT), 16'(seq[k]));
    end
    REQ = 4'h0; tick();

    // reset in the middle of init
    INIT_DATA = 4'hA; INIT_REQ = 1'b1; tick();
    INIT_REQ = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("midinit_wa", 16'({WA2,WA1,WA0}), 16'(k));
      chk("midinit_ld", 16'(LD_DATA), 16'hA);
    end
    #2 CLRN = 1'b0;
    #1 m_reset();
    chk_all();
    chk("rst_async_wr", 16'(WR), 16'h0);
    chk("rst_async_busy", 16'(BUSY), 16'h0);
    tick(); tick();
    CLRN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_nowr", 16'(WR), 16'h0);
    end

    // single requester held high
    REQ_ADDR = 12'd5; REQ_DATA = 16'h9; REQ = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("single_gnt", 16'(GNT), (k % 2 == 0) ? 16'h1 : 16'h0);
      if (k % 2 == 0) begin
        chk("single_wa", 16'({WA2,WA1,WA0}), 16'h5);
        chk("single_ld", 16'(LD_DATA), 16'h9);
      end
    end
    REQ = 4'h0; tick();

    // init beats a simultaneous request; a mid-sequence INIT_REQ is ignored
    REQ_ADDR = 12'(6) << 6; REQ_DATA = 16'h7 << 8;
    REQ = 4'b0100; INIT_REQ = 1'b1; INIT_DATA = 4'h3;
    tick();
    chk("prio_gnt", 16'(GNT), 16'h0);
    chk("prio_wr", 16'(WR), 16'h0);
    for (int k = 0; k < 8; k++) begin
      INIT_REQ = (k == 3);
      tick();
      chk("init_busy", 16'(BUSY), 16'h1);
      chk("init_wa", 16'({WA2,WA1,WA0}), 16'(k));
      chk("init_ld", 16'(LD_DATA), 16'h3);
    end
    INIT_REQ = 1'b0;
    tick();
    chk("post_init_busy", 16'(BUSY), 16'h0);
    chk("post_init_gnt", 16'(GNT), 16'h4);

    // pointer survives init
    REQ = 4'h0; tick();
    INIT_REQ = 1'b1; tick();
    INIT_REQ = 1'b0;
    REQ_ADDR = {3'd1, 3'd2, 3'd3, 3'd4}; REQ_DATA = 16'h1234; REQ = 4'hF;
    for (int k = 0; k < 8; k++) tick();
    tick(); chk("fair_gnt0", 16'(GNT), 16'h8);
    tick(); chk("fair_gnt1", 16'(GNT), 16'h1);
    REQ = 4'h0; tick();

    // end to end through the register file
    INIT_DATA = 4'hF; INIT_REQ = 1'b1; tick();
    INIT_REQ = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    REQ_ADDR = 12'(2) << 3; REQ_DATA = 16'h6 << 4; REQ = 4'b0010;
    tick(); chk("e2e_gnt", 16'(GNT), 16'h2);
    REQ = 4'h0; tick();
    for (int a = 0; a < 8; a++)
      chk($sformatf("e2e_rf%0d", a), 16'(rf[a]), (a == 2) ? 16'h6 : 16'hF);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      REQ       = 4'($urandom);
      REQ_ADDR  = 12'($urandom);
      REQ_DATA  = 16'($urandom);
      INIT_REQ  = ($urandom_range(0, 15) == 0);
      INIT_DATA = 4'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
